// File: rtl/vec_pe_pkg.sv
// Shared types and defaults for the dot-product feeder / PE pair.
package vec_pe_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int C_DEFAULT       = 8;
    localparam int DEPTH           = $clog2(C_DEFAULT);
    localparam int TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/vec_mul_feeder.sv
// Packs a serial (x, k) stream into C-lane vectors, runs one PE dot-product
// per vector and hands the result (or a timeout marker) downstream.
module vec_mul_feeder
    import vec_pe_pkg::*;
#(
    parameter int C       = C_DEFAULT,
    parameter int W_X     = 8,
    parameter int W_K     = 8,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_X-1:0]   in_x,
    input  logic [W_K-1:0]   in_k,
    input  logic             in_last,
    output logic             mul_enable,
    output logic [C*W_X-1:0] mul_x,
    output logic [C*W_K-1:0] mul_k,
    input  logic [W_X-1:0]   mul_y,
    input  logic             mul_valid,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W_X-1:0]   res_data,
    output logic             res_err
);

    localparam int CW = (C > 1) ? $clog2(C) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [TW-1:0]           tcnt_q, tcnt_d;
    logic [C-1:0][W_X-1:0]   x_q, x_d;
    logic [C-1:0][W_K-1:0]   k_q, k_d;
    logic                    in_ready_q, in_ready_d;
    logic                    mul_enable_q, mul_enable_d;
    logic                    res_valid_q, res_valid_d;
    logic [W_X-1:0]          res_data_q, res_data_d;
    logic                    res_err_q, res_err_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tcnt_d       = tcnt_q;
        x_d          = x_q;
        k_d          = k_q;
        in_ready_d   = in_ready_q;
        mul_enable_d = mul_enable_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_err_d    = res_err_q;

        unique case (state_q)
            FILL: begin
                in_ready_d   = 1'b1;
                mul_enable_d = 1'b0;
                if (in_valid && in_ready_q) begin
                    x_d[cnt_q] = in_x;
                    k_d[cnt_q] = in_k;
                    if (in_last || cnt_q == CW'(C - 1)) begin
                        // Lanes above the closing element are padded so stale data never reaches the PE.
                        for (int i = 0; i < C; i++) begin
                            if (i > int'(cnt_q)) begin
                                x_d[i] = '0;
                                k_d[i] = '0;
                            end
                        end
                        cnt_d        = '0;
                        state_d      = ISSUE;
                        in_ready_d   = 1'b0;
                        mul_enable_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (mul_valid) begin
                    res_data_d   = mul_y;
                    res_err_d    = 1'b0;
                    res_valid_d  = 1'b1;
                    mul_enable_d = 1'b0;
                    state_d      = DRAIN;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    res_data_d   = '0;
                    res_err_d    = 1'b1;
                    res_valid_d  = 1'b1;
                    mul_enable_d = 1'b0;
                    state_d      = DRAIN;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            DRAIN: begin
                mul_enable_d = 1'b0;
                in_ready_d   = 1'b0;
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    tcnt_d      = '0;
                    in_ready_d  = 1'b1;
                    state_d     = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            cnt_q        <= '0;
            tcnt_q       <= '0;
            x_q          <= '0;
            k_q          <= '0;
            in_ready_q   <= 1'b0;
            mul_enable_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tcnt_q       <= tcnt_d;
            x_q          <= x_d;
            k_q          <= k_d;
            in_ready_q   <= in_ready_d;
            mul_enable_q <= mul_enable_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_err_q    <= res_err_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mul_enable = mul_enable_q;
    assign mul_x      = x_q;
    assign mul_k      = k_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_err    = res_err_q;

endmodule

// File: tb/tb_vec_mul_feeder.sv
// Directed bench for vec_mul_feeder driven by a behavioural PE with a stub mode.
module tb_vec_mul_feeder;

    localparam int C   = 8;
    localparam int LAT = $clog2(C) + 3;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [7:0]     in_x;
    logic [7:0]     in_k;
    logic           in_last;
    logic           mul_enable;
    logic [63:0]    mul_x;
    logic [63:0]    mul_k;
    logic [7:0]     mul_y;
    logic           mul_valid;
    logic           res_valid;
    logic           res_ready;
    logic [7:0]     res_data;
    logic           res_err;

    logic           stub;
    int             pe_cnt;
    logic signed [31:0] psum;
    int             total;
    int             bad;

    vec_mul_feeder #(.C(C), .W_X(8), .W_K(8), .TIMEOUT(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_k       (in_k),
        .in_last    (in_last),
        .mul_enable (mul_enable),
        .mul_x      (mul_x),
        .mul_k      (mul_k),
        .mul_y      (mul_y),
        .mul_valid  (mul_valid),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_err    (res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural PE: result pulse LAT cycles into the enable window; stub never answers.
    always_ff @(posedge clk) begin
        if (!mul_enable) pe_cnt <= 0;
        else             pe_cnt <= pe_cnt + 1;
    end

    always_comb begin
        psum = '0;
        for (int i = 0; i < C; i++)
            psum = psum + $signed(mul_x[i*8 +: 8]) * $signed(mul_k[i*8 +: 8]);
    end

    assign mul_y     = psum[7:0];
    assign mul_valid = !stub && mul_enable && (pe_cnt == LAT);

    task automatic send_pair(input logic [7:0] x, input logic [7:0] k, input logic last);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_x = x;
        in_k = k;
        in_last = last;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_wait in_ready=%0b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic send_vec(input int n, input logic [7:0] x, input logic [7:0] k, input logic use_last);
        for (int i = 0; i < n; i++)
            send_pair(x, k, use_last && (i == n - 1));
    endtask

    // Watches from the negedge after the closing accept until the result handshake completes.
    task automatic collect(output logic [7:0] d, output logic e, output int rvc, output int lat, output int wins);
        logic prev_en;
        rvc = 0; lat = -1; wins = 0; d = '0; e = 1'b0; prev_en = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if (mul_enable && !prev_en) wins++;
            prev_en = mul_enable;
            if (res_valid) begin
                if (lat < 0) begin
                    lat = i;
                    d = res_data;
                    e = res_err;
                end
                rvc++;
            end
            if (lat >= 0 && !res_valid) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({in_ready, mul_enable, res_valid, res_err} !== 4'b0 || res_data !== 8'h00 ||
            mul_x !== 64'h0 || mul_k !== 64'h0) begin
            bad++;
            $display("FAIL reset_values rdy=%0b en=%0b rv=%0b err=%0b data=%h x=%h k=%h required all 0",
                     in_ready, mul_enable, res_valid, res_err, res_data, mul_x, mul_k);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready_rise in_ready=%0b required 1", in_ready);
        end
    endtask

    task automatic test_full();
        logic [7:0] d; logic e; int rvc, lat, wins;
        send_vec(8, 8'd1, 8'd2, 1'b1);
        total++;
        if (mul_enable !== 1'b1) begin
            bad++;
            $display("FAIL full_enable_latency mul_enable=%0b required 1", mul_enable);
        end
        collect(d, e, rvc, lat, wins);
        total++;
        if (d !== 8'd16 || e !== 1'b0) begin
            bad++;
            $display("FAIL full_result data=%0d err=%0b required 16 0", d, e);
        end
        total++;
        if (rvc !== 1 || wins !== 1 || lat !== LAT + 1) begin
            bad++;
            $display("FAIL full_timing rv_cycles=%0d windows=%0d lat=%0d required 1 1 %0d", rvc, wins, lat, LAT + 1);
        end
    endtask

    task automatic test_short();
        logic [7:0] d; logic e; int rvc, lat, wins;
        send_vec(3, 8'd3, 8'd4, 1'b1);
        total++;
        if (mul_x !== 64'h0000_0000_0003_0303 || mul_k !== 64'h0000_0000_0004_0404) begin
            bad++;
            $display("FAIL short_padding x=%h k=%h required 0000000000030303 0000000000040404", mul_x, mul_k);
        end
        collect(d, e, rvc, lat, wins);
        total++;
        if (d !== 8'd36 || e !== 1'b0 || rvc !== 1) begin
            bad++;
            $display("FAIL short_result data=%0d err=%0b rvc=%0d required 36 0 1", d, e, rvc);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] d; logic e; int rvc, lat, wins;
        send_vec(8, 8'd127, 8'd127, 1'b0);
        collect(d, e, rvc, lat, wins);
        total++;
        if (d !== 8'd8 || e !== 1'b0) begin
            bad++;
            $display("FAIL wrap_pos data=%0d err=%0b required 8 0", d, e);
        end
        send_vec(8, 8'hFF, 8'd1, 1'b0);
        collect(d, e, rvc, lat, wins);
        total++;
        if (d !== 8'hF8 || e !== 1'b0) begin
            bad++;
            $display("FAIL wrap_neg data=%h err=%0b required f8 0", d, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d; logic e; int rvc, lat, wins, t;
        res_ready = 1'b0;
        send_vec(8, 8'd2, 8'd3, 1'b0);
        t = 0;
        while (!res_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (res_valid !== 1'b1 || res_data !== 8'd48 || in_ready !== 1'b0 || mul_enable !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold[%0d] rv=%0b data=%0d rdy=%0b en=%0b required 1 48 0 0",
                         i, res_valid, res_data, in_ready, mul_enable);
            end
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        total++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1 || mul_enable !== 1'b0) begin
            bad++;
            $display("FAIL stall_release rv=%0b rdy=%0b en=%0b required 0 1 0", res_valid, in_ready, mul_enable);
        end
        send_pair(8'd5, 8'd5, 1'b1);
        total++;
        if (mul_x !== 64'h5 || mul_k !== 64'h5 || mul_enable !== 1'b1) begin
            bad++;
            $display("FAIL single_lane x=%h k=%h en=%0b required 5 5 1", mul_x, mul_k, mul_enable);
        end
        collect(d, e, rvc, lat, wins);
        total++;
        if (d !== 8'd25 || e !== 1'b0 || wins !== 1) begin
            bad++;
            $display("FAIL single_result data=%0d err=%0b windows=%0d required 25 0 1", d, e, wins);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] d; logic e; int rvc, lat, wins;
        stub = 1'b1;
        send_vec(8, 8'd1, 8'd1, 1'b0);
        collect(d, e, rvc, lat, wins);
        total++;
        if (d !== 8'd0 || e !== 1'b1 || rvc !== 1 || lat !== 64) begin
            bad++;
            $display("FAIL timeout data=%0d err=%0b rvc=%0d lat=%0d required 0 1 1 64", d, e, rvc, lat);
        end
        stub = 1'b0;
        send_vec(4, 8'd2, 8'hFD, 1'b1);
        collect(d, e, rvc, lat, wins);
        total++;
        if (d !== 8'hE8 || e !== 1'b0) begin
            bad++;
            $display("FAIL after_timeout data=%h err=%0b required e8 0", d, e);
        end
    endtask

    task automatic test_reset_mid_issue();
        logic [7:0] d; logic e; int rvc, lat, wins, seen;
        send_vec(8, 8'd1, 8'd1, 1'b1);
        repeat (2) @(negedge clk);
        total++;
        if (mul_enable !== 1'b1) begin
            bad++;
            $display("FAIL abort_pre en=%0b required 1", mul_enable);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (mul_enable !== 1'b0 || in_ready !== 1'b0 || mul_x !== 64'h0) begin
            bad++;
            $display("FAIL abort_reset en=%0b rdy=%0b x=%h required 0 0 0", mul_enable, in_ready, mul_x);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_ready in_ready=%0b required 1", in_ready);
        end
        seen = 0;
        repeat (20) begin
            if (res_valid) seen++;
            @(negedge clk);
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL abort_no_result rv_cycles=%0d required 0", seen);
        end
        send_vec(2, 8'd4, 8'd4, 1'b1);
        collect(d, e, rvc, lat, wins);
        total++;
        if (d !== 8'd32 || e !== 1'b0) begin
            bad++;
            $display("FAIL abort_recover data=%0d err=%0b required 32 0", d, e);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        stub = 1'b0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_x = '0;
        in_k = '0;
        in_last = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_full();
        test_short();
        test_wrap();
        test_back_to_back();
        test_timeout();
        test_reset_mid_issue();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
